// File: rtl/ahb_dma_sched.sv
// rtl/ahb_dma_sched.sv - round-robin multi-channel DMA block request scheduler
// Optional interrupt output guarded by DMA_SCHED_IRQ_EN.
module ahb_dma_sched #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 16,
  parameter int BSIZE_W = 5,
  parameter int LVL_W   = 8,
  parameter int CH_W    = 2
) (
  input  logic                      hclk,
  input  logic                      hresetn,
  input  logic [NUM_CH-1:0]         ch_en,
  input  logic [NUM_CH-1:0]         ch_load,
  input  logic [NUM_CH*CNT_W-1:0]   ch_count,
  input  logic [BSIZE_W-1:0]        block_size,
  input  logic [NUM_CH*LVL_W-1:0]   in_space,
  input  logic [NUM_CH*LVL_W-1:0]   out_level,
  input  logic                      req_done,
`ifdef DMA_SCHED_IRQ_EN
  input  logic [NUM_CH-1:0]         irq_mask,
  input  logic [NUM_CH-1:0]         done_clr,
  output logic                      irq,
`endif
  output logic                      rd_req,
  output logic                      wr_req,
  output logic [CH_W-1:0]           req_ch,
  output logic                      rd_update,
  output logic                      wr_update,
  output logic [CH_W-1:0]           upd_ch,
  output logic [NUM_CH-1:0]         ch_busy,
  output logic [NUM_CH-1:0]         ch_done
);

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

  state_t            state;
  logic [CH_W-1:0]   ptr;
  logic [CNT_W-1:0]  rd_left [NUM_CH];
  logic [CNT_W-1:0]  wr_left [NUM_CH];
  logic [NUM_CH-1:0] wr_elig;
  logic [NUM_CH-1:0] rd_elig;
  logic [NUM_CH-1:0] load_ok;
  logic [NUM_CH-1:0] done_nxt;
  logic [LVL_W-1:0]  bs_ext;
  logic              pick_found;
  logic              pick_wr;
  logic [CH_W-1:0]   pick_ch;

  assign bs_ext = LVL_W'(block_size);

  always_comb begin
    wr_elig = '0;
    rd_elig = '0;
    load_ok = '0;
    ch_busy = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_busy[i] = (rd_left[i] != '0) || (wr_left[i] != '0);
      load_ok[i] = ch_load[i] && !(state == REQ && req_ch == CH_W'(i));
      wr_elig[i] = ch_en[i] && (wr_left[i] != '0) && (block_size != '0) &&
                   (out_level[i*LVL_W +: LVL_W] >= bs_ext);
      // Read-ahead is bounded so a channel never runs far ahead of its writes.
      rd_elig[i] = ch_en[i] && (rd_left[i] != '0) && (block_size != '0) &&
                   (in_space[i*LVL_W +: LVL_W] >= bs_ext) &&
                   !({1'b0, wr_left[i]} > ({1'b0, rd_left[i]} + (CNT_W+1)'(1)));
    end
  end

  always_comb begin
    pick_found = 1'b0;
    pick_wr    = 1'b0;
    pick_ch    = '0;
    for (int k = 0; k < NUM_CH; k++) begin : scan
      int idx;
      idx = (int'(ptr) + k) % NUM_CH;
      if (!pick_found && (wr_elig[idx] || rd_elig[idx])) begin
        pick_found = 1'b1;
        pick_wr    = wr_elig[idx];
        pick_ch    = CH_W'(idx);
      end
    end
  end

  always_comb begin
    done_nxt = ch_done & ~load_ok;
`ifdef DMA_SCHED_IRQ_EN
    done_nxt = done_nxt & ~done_clr;
`endif
    // Completion set is applied last so it wins over any clear.
    if (state == REQ && req_done) begin
      if ((rd_req && rd_left[req_ch] == CNT_W'(1) && wr_left[req_ch] == '0) ||
          (wr_req && wr_left[req_ch] == CNT_W'(1) && rd_left[req_ch] == '0))
        done_nxt[req_ch] = 1'b1;
    end
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state     <= IDLE;
      ptr       <= '0;
      rd_req    <= 1'b0;
      wr_req    <= 1'b0;
      req_ch    <= '0;
      rd_update <= 1'b0;
      wr_update <= 1'b0;
      upd_ch    <= '0;
      ch_done   <= '0;
`ifdef DMA_SCHED_IRQ_EN
      irq       <= 1'b0;
`endif
      for (int i = 0; i < NUM_CH; i++) begin
        rd_left[i] <= '0;
        wr_left[i] <= '0;
      end
    end else begin
      rd_update <= 1'b0;
      wr_update <= 1'b0;
      ch_done   <= done_nxt;
`ifdef DMA_SCHED_IRQ_EN
      irq       <= |(done_nxt & irq_mask);
`endif
      for (int i = 0; i < NUM_CH; i++) begin
        if (load_ok[i]) begin
          rd_left[i] <= ch_count[i*CNT_W +: CNT_W];
          wr_left[i] <= ch_count[i*CNT_W +: CNT_W];
        end
      end
      case (state)
        IDLE: begin
          if (pick_found) begin
            state  <= REQ;
            req_ch <= pick_ch;
            wr_req <= pick_wr;
            rd_req <= !pick_wr;
          end
        end
        REQ: begin
          if (req_done) begin
            rd_req    <= 1'b0;
            wr_req    <= 1'b0;
            rd_update <= rd_req;
            wr_update <= wr_req;
            upd_ch    <= req_ch;
            if (rd_req) rd_left[req_ch] <= rd_left[req_ch] - CNT_W'(1);
            else        wr_left[req_ch] <= wr_left[req_ch] - CNT_W'(1);
            ptr   <= (req_ch == CH_W'(NUM_CH-1)) ? '0 : req_ch + CH_W'(1);
            state <= GAP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
